trng_word_controller: RTL and testbench



---
 rtl/trng_pkg.sv | 23 ++
 rtl/trng_rct_monitor.sv | 42 ++++
 rtl/trng_word_controller.sv | 146 ++++++++++++++
 tb/tb_trng_word_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types, default parameters and counter-width helper for the TRNG word controller.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    PRESENT,
    FAIL
  } state_t;

  localparam int unsigned DEF_WORD_W      = 32;
  localparam int unsigned DEF_SAMPLE_DIV  = 4;
  localparam int unsigned DEF_WARMUP_BITS = 64;
  localparam int unsigned DEF_RCT_LIMIT   = 16;
  localparam int unsigned DEF_CNT_W       = 8;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_rct_monitor.sv
// Repetition-count health test on the raw entropy bit, sampled on each strobe.
module trng_rct_monitor
  import trng_pkg::*;
#(
  parameter int unsigned RCT_LIMIT = DEF_RCT_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic raw_bit,
  input  logic restart,
  output logic fail
);

  localparam int unsigned RUN_W = cnt_width(RCT_LIMIT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RCT_LIMIT - 1);

  logic [RUN_W-1:0] run;
  logic             prev;
  logic             have_prev;
  logic             same_bit;

  assign same_bit = have_prev && (raw_bit == prev);
  // Combinational so the trip can pre-empt a word completing in the same cycle.
  assign fail     = strobe && same_bit && (run == RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      run       <= '0;
      prev      <= 1'b0;
      have_prev <= 1'b0;
    end else if (restart) begin
      run       <= RUN_W'(1);
      have_prev <= 1'b0;
    end else if (strobe) begin
      prev      <= raw_bit;
      have_prev <= 1'b1;
      run       <= same_bit ? run + 1'b1 : RUN_W'(1);
    end
  end

endmodule

// File: rtl/trng_word_controller.sv
// Strobes the Von Neumann corrector, drops warm-up bits, packs words and
// delivers them over valid/ready while a repetition-count test guards the source.
module trng_word_controller
  import trng_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int unsigned WARMUP_BITS = DEF_WARMUP_BITS,
  parameter int unsigned RCT_LIMIT   = DEF_RCT_LIMIT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [CNT_W-1:0]  req_words,
  input  logic              clr_fail,
  input  logic              raw_bit,
  output logic              vn_enable,
  input  logic              vn_valid,
  input  logic              vn_bit,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int unsigned DIV_W = cnt_width(SAMPLE_DIV);
  localparam int unsigned WB_W  = cnt_width(WARMUP_BITS);
  localparam int unsigned BIT_W = cnt_width(WORD_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WB_W-1:0]  WARM_LAST = WB_W'((WARMUP_BITS == 0) ? 0 : WARMUP_BITS - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_W - 1);

  state_t             state, next_state;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   words_left;
  logic [WB_W-1:0]    bits_seen;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  shreg;

  logic accept, cbit, rct_fail, warm_done, word_done, handshake;
  logic active, active_next;

  assign accept    = (state == IDLE) && req_valid && (req_words != '0);
  assign cbit      = vn_valid && vn_enable;
  assign warm_done = (state == WARMUP) && cbit && (bits_seen == WARM_LAST);
  assign word_done = (state == COLLECT) && cbit && (bit_cnt == WORD_LAST);
  assign handshake = (state == PRESENT) && word_valid && word_ready;
  assign busy      = (state != IDLE) && (state != FAIL);

  assign active      = (state == WARMUP) || (state == COLLECT);
  assign active_next = (next_state == WARMUP) || (next_state == COLLECT);

  trng_rct_monitor #(
    .RCT_LIMIT(RCT_LIMIT)
  ) u_rct (
    .clk     (clk),
    .reset   (reset),
    .strobe  (vn_enable),
    .raw_bit (raw_bit),
    .restart (accept),
    .fail    (rct_fail)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (WARMUP_BITS == 0) ? COLLECT : WARMUP;
      WARMUP:  if (rct_fail) next_state = FAIL;
               else if (warm_done) next_state = COLLECT;
      COLLECT: if (rct_fail) next_state = FAIL;
               else if (word_done) next_state = PRESENT;
      PRESENT: if (rct_fail) next_state = FAIL;
               else if (handshake) next_state = (words_left == CNT_W'(1)) ? IDLE : COLLECT;
      FAIL:    if (clr_fail) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      vn_enable   <= 1'b0;
      words_left  <= '0;
      bits_seen   <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      state <= next_state;

      // Divider only advances while staying in a sampling state, so leaving
      // WARMUP/COLLECT never emits a strobe into PRESENT or FAIL.
      if (active && active_next) begin
        if (div == DIV_LAST) begin
          div       <= '0;
          vn_enable <= 1'b1;
        end else begin
          div       <= div + 1'b1;
          vn_enable <= 1'b0;
        end
      end else begin
        div       <= '0;
        vn_enable <= 1'b0;
      end

      if (accept) begin
        words_left <= req_words;
        bits_seen  <= '0;
        bit_cnt    <= '0;
        shreg      <= '0;
      end

      if ((state == WARMUP) && cbit && !rct_fail)
        bits_seen <= bits_seen + 1'b1;

      if ((state == COLLECT) && cbit && !rct_fail) begin
        shreg   <= {shreg[WORD_W-2:0], vn_bit};
        bit_cnt <= bit_cnt + 1'b1;
        if (word_done) begin
          word_data  <= {shreg[WORD_W-2:0], vn_bit};
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end
      end

      if (handshake && !rct_fail) begin
        word_valid <= 1'b0;
        words_left <= words_left - 1'b1;
      end

      if (rct_fail) begin
        health_fail <= 1'b1;
        word_valid  <= 1'b0;
      end else if ((state == FAIL) && clr_fail) begin
        health_fail <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_word_controller.sv
// Scoreboard bench: the bench acts as the corrector, queues expected words and checks deliveries.
module tb_trng_word_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic       word_ready_a = 1'b0, word_ready_b = 1'b0;
  logic [7:0] req_words = '0;
  logic       clr_fail = 1'b0;
  logic       raw_bit = 1'b0;
  logic       vn_valid = 1'b0;
  logic       vn_bit = 1'b0;

  logic       en_a, wv_a, busy_a, hf_a;
  logic       en_b, wv_b, busy_b, hf_b;
  logic [7:0] data_a, data_b;

  logic       en_s, wv_s, busy_s;
  logic [7:0] data_s;

  int   checks = 0;
  int   errors = 0;
  int   pcyc = 0;
  bit   sel = 1'b0;
  bit   raw_stuck = 1'b0;
  bit   bit_q[$];
  logic [7:0] exp_q[$];
  int   strobe_q[$];

  always #5 clk = ~clk;

  trng_word_controller #(
    .WORD_W(8), .SAMPLE_DIV(1), .WARMUP_BITS(0), .RCT_LIMIT(16), .CNT_W(8)
  ) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_words(req_words),
    .clr_fail(clr_fail), .raw_bit(raw_bit), .vn_enable(en_a), .vn_valid(vn_valid),
    .vn_bit(vn_bit), .word_data(data_a), .word_valid(wv_a), .word_ready(word_ready_a),
    .busy(busy_a), .health_fail(hf_a)
  );

  trng_word_controller #(
    .WORD_W(8), .SAMPLE_DIV(4), .WARMUP_BITS(4), .RCT_LIMIT(16), .CNT_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_words(req_words),
    .clr_fail(clr_fail), .raw_bit(raw_bit), .vn_enable(en_b), .vn_valid(vn_valid),
    .vn_bit(vn_bit), .word_data(data_b), .word_valid(wv_b), .word_ready(word_ready_b),
    .busy(busy_b), .health_fail(hf_b)
  );

  assign en_s   = sel ? en_b : en_a;
  assign wv_s   = sel ? wv_b : wv_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign data_s = sel ? data_b : data_a;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Corrector model: a bit is presented only for strobe cycles; between strobes
  // vn_valid stays high with random data that must be ignored.
  always @(negedge clk) begin
    vn_valid = 1'b1;
    if (en_s) begin
      strobe_q.push_back(pcyc);
      vn_bit  = (bit_q.size() != 0) ? bit_q.pop_front() : 1'b0;
      raw_bit = raw_stuck ? 1'b0 : ~raw_bit;
    end else begin
      vn_bit = 1'($urandom);
      if (raw_stuck) raw_bit = 1'b0;
    end
  end

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bit_q.push_back(w[i]);
    exp_q.push_back(w);
  endtask

  task automatic push_junk(input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(1'($urandom));
  endtask

  task automatic request(input logic [7:0] n, output int at);
    @(negedge clk);
    req_words = n;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    at = pcyc;
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_word(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wv_s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    if (sel) word_ready_b = 1'b1; else word_ready_a = 1'b1;
    @(negedge clk);
    word_ready_a = 1'b0;
    word_ready_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({en_a, wv_a, busy_a, hf_a, data_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a: en/wv/busy/hf/data=%b%b%b%b/%h want all 0", en_a, wv_a, busy_a, hf_a, data_a);
    end
    checks++;
    if ({en_b, wv_b, busy_b, hf_b, data_b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_b: en/wv/busy/hf/data=%b%b%b%b/%h want all 0", en_b, wv_b, busy_b, hf_b, data_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int rq;
    bit ok;
    logic [7:0] e;
    sel = 1'b0;
    strobe_q.delete();
    push_word(8'hB2);
    request(8'd1, rq);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    wait_word(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: no word_valid within bound"); end
    e = exp_q.pop_front();
    checks++;
    if (data_a !== e) begin errors++; $display("FAIL basic_data: got %h want %h", data_a, e); end
    checks++;
    if (strobe_q.size() != 8 || strobe_q[0] - rq != 2) begin
      errors++;
      $display("FAIL basic_strobes: count %0d first %0d want 8 and 2", strobe_q.size(),
               (strobe_q.size() != 0) ? strobe_q[0] - rq : -1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wv_a !== 1'b1 || data_a !== 8'hB2 || en_a !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold: wv=%b data=%h en=%b want 1 b2 0", wv_a, data_a, en_a);
      end
    end
    handshake();
    checks++;
    if (wv_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: wv=%b busy=%b want 0 0", wv_a, busy_a);
    end
  endtask

  task automatic test_divider();
    int rq, bad;
    bit ok;
    logic [7:0] e;
    sel = 1'b1;
    strobe_q.delete();
    push_junk(4);
    push_word(8'h6C);
    request(8'd1, rq);
    wait_word(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div_timeout: no word_valid within bound"); end
    e = exp_q.pop_front();
    checks++;
    if (data_b !== e) begin errors++; $display("FAIL div_data: got %h want %h", data_b, e); end
    bad = 0;
    for (int i = 1; i < strobe_q.size(); i++)
      if (strobe_q[i] - strobe_q[i-1] != 4) bad++;
    checks++;
    if (strobe_q.size() != 12 || strobe_q[0] - rq != 5 || bad != 0) begin
      errors++;
      $display("FAIL div_period: count %0d first %0d bad_gaps %0d want 12 5 0", strobe_q.size(),
               (strobe_q.size() != 0) ? strobe_q[0] - rq : -1, bad);
    end
    handshake();
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL div_done: busy=%b want 0", busy_b); end
  endtask

  task automatic test_back_to_back();
    int rq;
    bit ok;
    logic [7:0] e;
    sel = 1'b1;
    strobe_q.delete();
    push_junk(4);
    push_word(8'hA7);
    push_word(8'h3D);
    request(8'd2, rq);
    wait_word(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout1: no first word"); end
    e = exp_q.pop_front();
    checks++;
    if (data_b !== e) begin errors++; $display("FAIL b2b_word1: got %h want %h", data_b, e); end
    repeat (10) @(negedge clk);
    checks++;
    if (wv_b !== 1'b1 || data_b !== e || strobe_q.size() != 12 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: wv=%b data=%h strobes=%0d busy=%b want 1 %h 12 1",
               wv_b, data_b, strobe_q.size(), busy_b, e);
    end
    handshake();
    checks++;
    if (wv_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mid: wv=%b busy=%b want 0 1", wv_b, busy_b);
    end
    wait_word(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout2: no second word"); end
    e = exp_q.pop_front();
    checks++;
    if (data_b !== e || strobe_q.size() != 20) begin
      errors++;
      $display("FAIL b2b_word2: got %h strobes %0d want %h 20", data_b, strobe_q.size(), e);
    end
    handshake();
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_done: busy=%b want 0", busy_b); end
  endtask

  task automatic test_health();
    int rq, bad;
    logic [7:0] e;
    sel = 1'b0;
    strobe_q.delete();
    raw_stuck = 1'b1;
    push_word(8'h5A);
    push_junk(8);
    word_ready_a = 1'b1;
    request(8'd4, rq);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wv_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL health_extra_word: unexpected word %h", data_a);
        end else begin
          e = exp_q.pop_front();
          if (data_a !== e) begin errors++; $display("FAIL health_word: got %h want %h", data_a, e); end
        end
      end
      if (hf_a) break;
    end
    word_ready_a = 1'b0;
    checks++;
    if (hf_a !== 1'b1 || strobe_q.size() != 16 || wv_a !== 1'b0 || busy_a !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL health_trip: hf=%b strobes=%0d wv=%b busy=%b pending=%0d want 1 16 0 0 0",
               hf_a, strobe_q.size(), wv_a, busy_a, exp_q.size());
    end
    bit_q.delete();
    request(8'd1, rq);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || en_a !== 1'b0 || hf_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL health_req_ignored: %0d bad cycles want 0", bad); end
    clr_fail = 1'b1;
    @(negedge clk);
    clr_fail = 1'b0;
    checks++;
    if (hf_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL health_clear: hf=%b busy=%b want 0 0", hf_a, busy_a);
    end
    raw_stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rq;
    bit ok;
    logic [7:0] e;
    sel = 1'b0;
    bit_q.delete();
    repeat (3) bit_q.push_back(1'b1);
    request(8'd1, rq);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({en_a, wv_a, busy_a, hf_a, data_a} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs: en/wv/busy/hf/data=%b%b%b%b/%h want all 0", en_a, wv_a, busy_a, hf_a, data_a);
    end
    reset = 1'b0;
    bit_q.delete();
    strobe_q.delete();
    push_word(8'hC3);
    request(8'd1, rq);
    wait_word(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || data_a !== e || strobe_q.size() != 8) begin
      errors++;
      $display("FAIL midreset_word: ok=%b got %h strobes %0d want %h 8", ok, data_a, strobe_q.size(), e);
    end
    handshake();
  endtask

  task automatic test_ignored_req();
    int rq, bad;
    bit ok;
    logic [7:0] e;
    sel = 1'b0;
    strobe_q.delete();
    request(8'd0, rq);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || en_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || strobe_q.size() != 0) begin
      errors++;
      $display("FAIL zero_req: bad %0d strobes %0d want 0 0", bad, strobe_q.size());
    end
    push_word(8'h96);
    request(8'd1, rq);
    request(8'hFF, rq);
    wait_word(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || data_a !== e) begin errors++; $display("FAIL busy_req_word: ok=%b got %h want %h", ok, data_a, e); end
    handshake();
    checks++;
    if (busy_a !== 1'b0 || strobe_q.size() != 8) begin
      errors++;
      $display("FAIL busy_req_ignored: busy=%b strobes=%0d want 0 8", busy_a, strobe_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_back_to_back();
    test_health();
    test_reset_mid();
    test_ignored_req();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
